// File: rtl/seq_reduce_unit.sv
// Multi-cycle bitwise reduction of {a, b} (OR/AND/XOR/NOR), CHUNK bits per cycle.
// Optional: define SEQ_REDUCE_EARLY_TERM_EN to leave RUN as soon as the result is decided.
module seq_reduce_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned CNT_W = $clog2((2 * WIDTH) / CHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             y_o,
    output logic [CNT_W-1:0] beats_o
);

    localparam int unsigned DATA_W    = 2 * WIDTH;
    localparam int unsigned NUM_BEATS = DATA_W / CHUNK;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [1:0]          op_q, op_d;
    logic                acc_q, acc_d;
    logic                y_q, y_d;
    logic [CNT_W-1:0]    beats_q, beats_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CHUNK-1:0]    chunk;
    logic                acc_next;
    logic                last_beat;
    logic                early_exit;

    // Fold the current chunk into the accumulator; NOR accumulates as OR.
    always_comb begin
        chunk = sr_q[CHUNK-1:0];
        case (op_q)
            OP_AND:  acc_next = acc_q & (&chunk);
            OP_XOR:  acc_next = acc_q ^ (^chunk);
            default: acc_next = acc_q | (|chunk);
        endcase
        last_beat = (beats_q == CNT_W'(NUM_BEATS - 1));
`ifdef SEQ_REDUCE_EARLY_TERM_EN
        early_exit = (op_q == OP_AND) ? ~acc_next : ((op_q != OP_XOR) & acc_next);
`else
        early_exit = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        op_d    = op_q;
        acc_d   = acc_q;
        y_d     = y_q;
        beats_d = beats_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    sr_d    = {a_i, b_i};
                    op_d    = op_i;
                    acc_d   = (op_i == OP_AND);
                    beats_d = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = acc_next;
                sr_d    = sr_q >> CHUNK;
                beats_d = beats_q + CNT_W'(1);
                if (last_beat || early_exit) begin
                    state_d = ST_DONE;
                    y_d     = (op_q == OP_NOR) ? ~acc_next : acc_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            op_q    <= OP_OR;
            acc_q   <= 1'b0;
            y_q     <= 1'b0;
            beats_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            beats_q <= beats_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign y_o     = y_q;
    assign beats_o = beats_q;

endmodule

// File: tb/tb_seq_reduce_unit.sv
// Bench for seq_reduce_unit (WIDTH=4, CHUNK=2): directed cases plus random traffic against a transaction model.
module tb_seq_reduce_unit;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CHUNK = 2;
    localparam int unsigned NB    = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i, b_i;
    logic             busy_o, done_o, y_o;
    logic [CNT_W-1:0] beats_o;

    int checks = 0;
    int errors = 0;

    seq_reduce_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .busy_o(busy_o), .done_o(done_o), .y_o(y_o), .beats_o(beats_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result and RUN length for one operation, straight from the reduction rules.
    function automatic void ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, output logic y, output int nbeats);
        logic [2*WIDTH-1:0] v;
        logic [CHUNK-1:0]   ch;
        v = {a, b};
        case (op)
            2'b00: y = |v;
            2'b01: y = &v;
            2'b10: y = ^v;
            default: y = ~|v;
        endcase
        nbeats = NB;
`ifdef SEQ_REDUCE_EARLY_TERM_EN
        for (int k = NB - 1; k >= 0; k--) begin
            ch = CHUNK'(v >> (k * CHUNK));
            if ((op == 2'b01) && (ch != {CHUNK{1'b1}})) nbeats = k + 1;
            if ((op == 2'b00 || op == 2'b11) && (ch != '0)) nbeats = k + 1;
        end
`endif
    endfunction

    // Transaction-level model: idle/busy with a countdown, updated on every clock edge.
    logic m_busy = 1'b0, m_done = 1'b0, m_y = 1'b0;
    int   m_beats = 0, m_left = 0, p_beats = 0;
    logic p_y = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_y = 1'b0; m_beats = 0; m_left = 0;
        end else if (!m_busy && start_i) begin
            ref_op(op_i, a_i, b_i, p_y, p_beats);
            m_busy = 1'b1; m_done = 1'b0; m_beats = 0; m_left = p_beats;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_y = p_y; m_beats = p_beats;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy", int'(busy_o), int'(m_busy));
        check("done", int'(done_o), int'(m_done));
        if (busy_o && done_o) check("busy_and_done", 1, 0);
        if (!m_busy) begin
            check("y", int'(y_o), int'(m_y));
            check("beats", int'(beats_o), m_beats);
        end
    end

    // Issue one op and wait (bounded) for done; returns in the DONE cycle.
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int ey, input int eb, input string tag);
        int cyc;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        while (!done_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, eb + 1);
        check({tag, "_y"}, int'(y_o), ey);
        check({tag, "_beats"}, int'(beats_o), eb);
    endtask

    int eb_or1, eb_and0;

    initial begin
`ifdef SEQ_REDUCE_EARLY_TERM_EN
        eb_or1 = 1; eb_and0 = 1;
`else
        eb_or1 = 4; eb_and0 = 4;
`endif
        rst = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_y", int'(y_o), 0);
        check("rst_beats", int'(beats_o), 0);

        run_op(2'b00, 4'b1111, 4'b1111, 1, eb_or1, "or_ones");
        @(negedge clk);
        run_op(2'b00, 4'b0000, 4'b0000, 0, 4, "or_zero");
        @(negedge clk);
        run_op(2'b11, 4'b0000, 4'b0000, 1, 4, "nor_zero");
        @(negedge clk);
        run_op(2'b10, 4'b1010, 4'b1010, 0, 4, "xor_even");
        @(negedge clk);
        run_op(2'b10, 4'b0100, 4'b0000, 1, 4, "xor_odd");
        @(negedge clk);
        run_op(2'b01, 4'b0100, 4'b0100, 0, eb_and0, "and_mixed");
        // Back-to-back: start in the DONE cycle is accepted with no IDLE gap.
        run_op(2'b01, 4'b1111, 4'b1111, 1, 4, "and_ones_b2b");
        check("b2b_idle_y", int'(y_o), 1);

        // start pulsed during RUN with other operands must be ignored.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; a_i = 4'b0000; b_i = 4'b0000;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; a_i = 4'b1111; b_i = 4'b1111;
        @(negedge clk);
        start_i = 1'b0;
        begin
            int n = 0;
            while (!done_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("ign_start_wait", n, 2);
        end
        check("ign_start_y", int'(y_o), 0);
        check("ign_start_beats", int'(beats_o), 4);
        @(negedge clk);
        run_op(2'b01, 4'b1111, 4'b1111, 1, 4, "and_ones");

        // Reset in RUN cycle 2 aborts without a done pulse.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b10; a_i = 4'b1100; b_i = 4'b0110;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        check("abort_y", int'(y_o), 0);
        check("abort_beats", int'(beats_o), 0);
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (done_o) seen++;
            end
            check("abort_no_done", seen, 0);
        end

        // Random traffic: starts, b2b, ignored starts, occasional resets.
        for (int i = 0; i < 1500; i++) begin
            start_i = ($urandom_range(0, 2) == 0);
            op_i    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin a_i = '0; b_i = '0; end
                1: begin a_i = '1; b_i = '1; end
                default: begin a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); end
            endcase
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start_i = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_reduce_unit.md
Name: seq_reduce_unit

Overview:
- Multi-cycle, parametrised bitwise reduction unit for the ALU; successor to the fixed 8-input OR reduction.
- Reduces the concatenation {a, b} (2*WIDTH bits) to one bit with a selectable operation (OR/AND/XOR/NOR), CHUNK bits per cycle.
- Start/busy/done handshake, so the ALU controller can sequence it like the other multi-cycle units.

Parameters:
- WIDTH, 32, width of each operand a and b; 2*WIDTH must be divisible by CHUNK.
- CHUNK, 8, bits reduced per RUN cycle; NUM_BEATS = 2*WIDTH/CHUNK.
- CNT_W, $clog2(NUM_BEATS+1), width of beat counter output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  2  00 OR, 01 AND, 10 XOR, 11 NOR; latched with operands
- a  input  WIDTH  operand, upper half of {a, b}
- b  input  WIDTH  operand, lower half of {a, b}
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- y  output  1  result; valid from done, held until the next accepted start
- beats  output  CNT_W  RUN cycles consumed by the last/current operation

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values (also applied when rst is high mid-operation): state=IDLE, busy=0, done=0, y=0, beats=0, accumulator=0. A reset aborts any operation and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> latch {a, b} into a shift register and latch op.
  - Load the accumulator with the identity: 1 for AND, 0 otherwise. Clear beats.
  - Go to RUN. busy rises the cycle after start is sampled.
- RUN, each cycle:
  - Combine the low CHUNK bits of the shift register into the accumulator (OR / AND / XOR; NOR uses OR).
  - Shift the register right by CHUNK and increment beats.
  - Chunk 0 = b[CHUNK-1:0]; the last chunk = a[WIDTH-1:WIDTH-CHUNK].
  - After NUM_BEATS chunks -> DONE. y = accumulator result, inverted for NOR, updated on the same edge.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in this cycle is accepted (back-to-back; same actions as IDLE -> RUN); otherwise go to IDLE.
- Latency: start sampled at edge N -> done high in the cycle after edge N+NUM_BEATS (NUM_BEATS+1 cycles after start).
- start in RUN is ignored; operand and op changes in RUN have no effect.
- y and beats hold their values in IDLE until the next accepted start. beats is cleared on accept.
- busy and done are never high together.

Optional Feature:
- Macro: SEQ_REDUCE_EARLY_TERM_EN.
- Defined:
  - RUN exits to DONE as soon as the result is decided: OR/NOR once the accumulator is 1, AND once it is 0. The chunk that decides the result is counted in beats.
  - XOR always runs all NUM_BEATS cycles.
- Undefined: every operation takes exactly NUM_BEATS RUN cycles; result values are identical in both builds.

Test Plan (WIDTH=4, CHUNK=2, NUM_BEATS=4):
- OR, a=4'b1111, b=4'b1111 -> done 5 cycles after start, y=1, beats=4 (beats=1 with SEQ_REDUCE_EARLY_TERM_EN).
- OR, a=4'b0000, b=4'b0000 -> y=0, beats=4; then NOR with the same operands -> y=1.
- XOR, a=4'b1010, b=4'b1010 -> y=0; XOR, a=4'b0100, b=4'b0000 -> y=1; both beats=4 in both builds.
- AND, a=4'b0100, b=4'b0100 -> y=0 (beats=1 with early term); AND with all-ones -> y=1.
- start pulsed in RUN cycle 2 with different operands -> ignored, first result unchanged. start asserted in the DONE cycle -> second operation accepted with no IDLE cycle.
- rst=1 in RUN cycle 2 -> next cycle busy=0, done=0, y=0, beats=0; no done pulse follows.
